// File: rtl/pow_sq_pkg.sv
// pow_sq_pkg: shared sizing helpers and parameter defaults for the repeated-squaring pipeline.
//   out_w(in_w, stages) : result width, in_w << stages
//   mode_w(stages)      : width of the per-sample mode field, $clog2(stages+1)
package pow_sq_pkg;

    localparam int IN_W_DEF   = 4;
    localparam int STAGES_DEF = 3;

    function automatic int out_w(input int in_w, input int stages);
        return in_w << stages;
    endfunction

    function automatic int mode_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pow_sq_stage.sv
// pow_sq_stage: one pipeline register stage that squares its operand or passes it through.
//   clk, rst_n        : clock, asynchronous active-low reset
//   adv               : shared advance enable; 0 freezes the stage
//   v_in/mode_in/d_in : sample from the previous stage (or the input port)
//   v_out/mode_out    : registered valid and the mode travelling with the sample
//   d_out             : registered data, twice the input width so the square is exact
module pow_sq_stage #(
    parameter int STAGE_IDX = 0,
    parameter int DIN_W     = 4,
    parameter int MODE_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    input  logic                 v_in,
    input  logic [MODE_W-1:0]    mode_in,
    input  logic [DIN_W-1:0]     d_in,
    output logic                 v_out,
    output logic [MODE_W-1:0]    mode_out,
    output logic [2*DIN_W-1:0]   d_out
);

    logic [2*DIN_W-1:0] d_ext;

    assign d_ext = (2*DIN_W)'(d_in);

    // Empty slots carry zero data so the final output reads 0 whenever it is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_out    <= 1'b0;
            mode_out <= '0;
            d_out    <= '0;
        end else if (adv) begin
            v_out    <= v_in;
            mode_out <= v_in ? mode_in : '0;
            d_out    <= !v_in ? '0 : (mode_in > MODE_W'(STAGE_IDX)) ? d_ext * d_ext : d_ext;
        end
    end

endmodule

// File: rtl/pow_sq_pipeline.sv
// pow_sq_pipeline: fully pipelined in^(2^mode) unit, one sample per cycle, valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready is the global advance)
//   in, mode            : unsigned operand and number of squarings (clamped to STAGES)
//   out_valid, out_ready: output handshake
//   out                 : zero-extended result, 0 when out_valid is low
//   out_cnt             : accepted-sample count, present only when POW_SQ_CNT_EN is defined
module pow_sq_pipeline
    import pow_sq_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int STAGES = STAGES_DEF,
    localparam int OUT_W  = out_w(IN_W, STAGES),
    localparam int MODE_W = mode_w(STAGES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in,
    input  logic [MODE_W-1:0] mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out
`ifdef POW_SQ_CNT_EN
    ,
    output logic [15:0]       out_cnt
`endif
);

    logic              adv;
    logic [MODE_W-1:0] mode_c;
    logic              unused_mode;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign mode_c   = (mode > MODE_W'(STAGES)) ? MODE_W'(STAGES) : mode;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [(IN_W<<k)-1:0]     din;
        logic                     vin;
        logic [MODE_W-1:0]        min;
        logic [(IN_W<<(k+1))-1:0] q;
        logic                     qv;
        logic [MODE_W-1:0]        qm;
        if (k == 0) begin : head
            assign din = in;
            assign vin = in_valid;
            assign min = mode_c;
        end else begin : body
            assign din = stg[k-1].q;
            assign vin = stg[k-1].qv;
            assign min = stg[k-1].qm;
        end
        pow_sq_stage #(
            .STAGE_IDX(k),
            .DIN_W    (IN_W << k),
            .MODE_W   (MODE_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .v_in    (vin),
            .mode_in (min),
            .d_in    (din),
            .v_out   (qv),
            .mode_out(qm),
            .d_out   (q)
        );
    end

    assign out_valid   = stg[STAGES-1].qv;
    assign out         = stg[STAGES-1].q;
    assign unused_mode = ^stg[STAGES-1].qm;

`ifdef POW_SQ_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_cnt <= '0;
        else if (in_valid && in_ready) out_cnt <= out_cnt + 16'd1;
    end
`endif

endmodule
